// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default bit period, data width
// and the receive FSM state encoding.
package uart_rx_pkg;

  // 9600 baud at a 10 MHz system clock.
  localparam int DEFAULT_CLKS_PER_BIT = 1042;
  localparam int DATA_W               = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Generic 2-flop synchronizer for a single asynchronous input. Both flops
// take RST_VAL on reset so the downstream logic sees a defined level.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Two-stage resynchronization of d into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Confirms the start bit at mid-bit, samples each data
// bit one bit period later (LSB first), and checks the stop bit. A low stop
// bit reports one framing error and then waits for the line to go high again.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_serial,
  output logic              o_rx_dv,
  output logic [DATA_W-1:0] o_rx_byte,
  output logic              o_rx_active,
  output logic              o_rx_frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic              rx_s;
  rx_state_t         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2:0]        idx_reg, idx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] byte_reg, byte_next;
  logic              dv_reg, dv_next;
  logic              ferr_reg, ferr_next;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_rx_serial),
    .q   (rx_s)
  );

  // State, counters, shift register and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      byte_reg  <= '0;
      dv_reg    <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      byte_reg  <= byte_next;
      dv_reg    <= dv_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic; the strobes default low so each lasts one cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    byte_next  = byte_reg;
    dv_next    = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg != HALF) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          // Line back high at mid start bit: a glitch, drop it silently.
          cnt_next   = '0;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_reg != LAST) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s;
          if (idx_reg == 3'd7) begin
            idx_next   = '0;
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_reg != LAST) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          cnt_next = '0;
          if (rx_s) begin
            byte_next  = shift_reg;
            dv_next    = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break reports only once.
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_rx_dv        = dv_reg;
  assign o_rx_frame_err = ferr_reg;
  assign o_rx_byte      = byte_reg;
  assign o_rx_active    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit. Each stimulus task schedules the
// expected outputs on an absolute cycle timeline derived from frame timing
// (edge 0 = first edge sampling the start bit low); a compare process checks
// every cycle against that timeline.
module tb_uart_rx;
  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;
  localparam int N    = 8192;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       line = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       act;
  logic       ferr;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_serial    (line),
    .o_rx_dv        (dv),
    .o_rx_byte      (rbyte),
    .o_rx_active    (act),
    .o_rx_frame_err (ferr)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  bit         exp_dv   [N];
  bit         exp_ferr [N];
  bit         exp_act  [N];
  bit         byte_set [N];
  logic [7:0] byte_val [N];
  logic [7:0] model_byte = 8'h00;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         dv_seen = 0;
  int         ferr_seen = 0;
  int         last_dv_cyc = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  task automatic mark_act(input int a, input int b);
    for (int i = a; i <= b; i++) if (i >= 0 && i < N) exp_act[i] = 1'b1;
  endtask

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame; with stop_bit=0 the line stays low brk extra clocks.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int brk, output int e);
    int s;
    e = cyc + 1;
    s = e + 3 + HALF + 9 * C;
    if (stop_bit) begin
      mark_act(e + 2, s - 1);
      exp_dv[s]   = 1'b1;
      byte_set[s] = 1'b1;
      byte_val[s] = b;
    end else begin
      exp_ferr[s] = 1'b1;
      mark_act(e + 2, e + 10 * C + brk + 1);
    end
    hold(1'b0, C);
    for (int k = 0; k < 8; k++) hold(b[k], C);
    hold(stop_bit, C + brk);
    line = 1'b1;
  endtask

  task automatic glitch(input int len, output int e);
    e = cyc + 1;
    mark_act(e + 2, e + 2 + HALF);
    hold(1'b0, len);
    line = 1'b1;
  endtask

  // Cycle counter: value equals the number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the scheduled timeline.
  initial forever begin
    @(negedge clk);
    if (rst) model_byte = 8'h00;
    else if (cyc < N && byte_set[cyc]) model_byte = byte_val[cyc];
    if (cyc < N) begin
      check("rx_dv", {31'd0, dv}, {31'd0, exp_dv[cyc]});
      check("rx_frame_err", {31'd0, ferr}, {31'd0, exp_ferr[cyc]});
      check("rx_active", {31'd0, act}, {31'd0, exp_act[cyc]});
      check("rx_byte", {24'd0, rbyte}, {24'd0, model_byte});
      check("dv_ferr_exclusive", {31'd0, dv & ferr}, 32'd0);
    end
    if (dv) begin
      dv_seen++;
      last_dv_cyc = cyc;
      $display("rx byte %02h at cycle %0d", rbyte, cyc);
    end
    if (ferr) begin
      ferr_seen++;
      $display("frame error at cycle %0d", cyc);
    end
  end

  initial begin
    int e;
    logic [7:0] sweep [8];
    sweep = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'hC3};

    repeat (3) @(posedge clk);
    #1;
    check("reset_byte", {24'd0, rbyte}, 32'h00);
    check("reset_active", {31'd0, act}, 32'd0);
    rst = 1'b0;
    hold(1'b1, 5);

    // Latency: stop sampled at edge 154, dv high in the cycle after it.
    send(8'hA5, 1'b1, 0, e);
    hold(1'b1, 4);
    check("lat_dv_cycle", last_dv_cyc, e + 154);
    check("lat_byte", {24'd0, rbyte}, 32'hA5);
    check("lat_model_dv", {31'd0, exp_dv[e + 154]}, 32'd1);
    check("lat_model_act_first", {31'd0, exp_act[e + 2]}, 32'd1);
    check("lat_model_act_edge1", {31'd0, exp_act[e + 1]}, 32'd0);
    check("lat_model_act_end", {31'd0, exp_act[e + 154]}, 32'd0);

    // Glitch rejection followed by a good frame.
    glitch(5, e);
    hold(1'b1, 30);
    check("glitch_no_dv", dv_seen, 1);
    check("glitch_no_ferr", ferr_seen, 0);
    send(8'h3C, 1'b1, 0, e);
    hold(1'b1, 4);
    check("after_glitch_byte", {24'd0, rbyte}, 32'h3C);

    // Framing error with a 30-bit break, then a good frame.
    send(8'h81, 1'b0, 30 * C, e);
    hold(1'b1, 4);
    check("ferr_count", ferr_seen, 1);
    check("ferr_byte_held", {24'd0, rbyte}, 32'h3C);
    check("ferr_no_dv", dv_seen, 2);
    send(8'h42, 1'b1, 0, e);
    hold(1'b1, 4);
    check("after_break_byte", {24'd0, rbyte}, 32'h42);

    // Back-to-back frames, no idle gap.
    send(8'h55, 1'b1, 0, e);
    send(8'h56, 1'b1, 0, e);
    send(8'h57, 1'b1, 0, e);
    hold(1'b1, 4);
    check("b2b_count", dv_seen, 6);
    check("b2b_last_byte", {24'd0, rbyte}, 32'h57);

    // Reset asserted in the middle of data bit 3 of 0xFF.
    e = cyc + 1;
    mark_act(e + 2, e + 4 * C + C / 2 - 2);
    hold(1'b0, C);
    for (int k = 0; k < 3; k++) hold(1'b1, C);
    hold(1'b1, C / 2);
    rst = 1'b1;
    #1;
    check("rst_mid_dv", {31'd0, dv}, 32'd0);
    check("rst_mid_ferr", {31'd0, ferr}, 32'd0);
    check("rst_mid_active", {31'd0, act}, 32'd0);
    check("rst_mid_byte", {24'd0, rbyte}, 32'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 10);
    send(8'h69, 1'b1, 0, e);
    hold(1'b1, 4);
    check("after_rst_byte", {24'd0, rbyte}, 32'h69);

    // Byte sweep with short idle gaps.
    for (int i = 0; i < 8; i++) begin
      send(sweep[i], 1'b1, 0, e);
      hold(1'b1, 2);
    end
    hold(1'b1, 4);
    check("sweep_last_byte", {24'd0, rbyte}, 32'hC3);
    check("total_dv", dv_seen, 15);
    check("total_ferr", ferr_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
